ray_bounce_scheduler: RTL

RAY_BOUNCE_SCHEDULER -- requirements
Module: ray_bounce_scheduler

---
 rtl/ray_bounce_scheduler_pkg.sv | 14 +
 rtl/ray_ref_fifo.sv | 60 ++++++
 rtl/ray_bounce_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ray_bounce_scheduler_pkg.sv
// Shared definitions for the ray bounce scheduler: payload type, bounce-index
// width helper and the starvation limit used by the optional fairness guard.
package ray_bounce_scheduler_pkg;

  localparam int RAY_DATA_W   = 256;
  localparam int STARVE_LIMIT = 4;

  typedef logic [RAY_DATA_W-1:0] ray_payload_t;

  function automatic int bounce_width(input int max_bounce);
    return (max_bounce < 1) ? 1 : $clog2(max_bounce + 1);
  endfunction

endpackage

// File: rtl/ray_ref_fifo.sv
// Synchronous FIFO holding reflected rays (payload plus bounce index).
// The head entry is presented combinationally so the scheduler can grant it in the same cycle.
module ray_ref_fifo #(
  parameter int DATA_W   = 256,
  parameter int BOUNCE_W = 2,
  parameter int DEPTH    = 8,
  localparam int AW      = $clog2(DEPTH),
  localparam int CNT_W   = AW + 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [BOUNCE_W-1:0] wr_bounce,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   rd_data,
  output logic [BOUNCE_W-1:0] rd_bounce,
  output logic                full,
  output logic                empty,
  output logic [CNT_W-1:0]    count
);

  logic [DATA_W-1:0]   data_mem   [DEPTH];
  logic [BOUNCE_W-1:0] bounce_mem [DEPTH];
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                wr_ok;
  logic                rd_ok;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign wr_ok     = wr_en && !full;
  assign rd_ok     = rd_en && !empty;
  assign rd_data   = data_mem[rd_ptr_reg];
  assign rd_bounce = bounce_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      data_mem[wr_ptr_reg]   <= wr_data;
      bounce_mem[wr_ptr_reg] <= wr_bounce;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (wr_ok && !rd_ok)      count_reg <= count_reg + CNT_W'(1);
      else if (rd_ok && !wr_ok) count_reg <= count_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ray_bounce_scheduler.sv
// Merges primary rays and re-entering reflections into one output stream, reflections first.
// Define RAY_SCHED_STARVE_GUARD_EN to let a waiting primary through after a run of reflection grants.
module ray_bounce_scheduler
  import ray_bounce_scheduler_pkg::*;
#(
  parameter int NUM_PRIMARY  = 2,
  parameter int DATA_W       = 256,
  parameter int REF_DEPTH    = 8,
  parameter int MAX_BOUNCE   = 3,
  parameter int MAX_INFLIGHT = 16,
  localparam int BOUNCE_W    = bounce_width(MAX_BOUNCE),
  localparam int IF_W        = $clog2(MAX_INFLIGHT + 1),
  localparam int PTR_W       = (NUM_PRIMARY > 1) ? $clog2(NUM_PRIMARY) : 1,
  localparam int CNT_W       = $clog2(REF_DEPTH) + 1
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [NUM_PRIMARY-1:0]             prim_valid,
  input  logic [NUM_PRIMARY-1:0][DATA_W-1:0] prim_data,
  output logic [NUM_PRIMARY-1:0]             prim_ready,
  input  logic                               ref_valid,
  input  logic [DATA_W-1:0]                  ref_data,
  input  logic [BOUNCE_W-1:0]                ref_bounce,
  output logic                               ref_ready,
  output logic                               out_valid,
  output logic [DATA_W-1:0]                  out_data,
  output logic [BOUNCE_W-1:0]                out_bounce,
  input  logic                               out_ready,
  input  logic                               ray_done,
  output logic [IF_W-1:0]                    in_flight,
  output logic                               ref_fifo_full,
  output logic [15:0]                        drop_count
);

  logic                   out_valid_reg;
  logic [DATA_W-1:0]      out_data_reg;
  logic [BOUNCE_W-1:0]    out_bounce_reg;
  logic [IF_W-1:0]        in_flight_reg, in_flight_next;
  logic [15:0]            drop_count_reg;
  logic [PTR_W-1:0]       rr_ptr_reg, prim_sel;
  logic [NUM_PRIMARY-1:0] upper_req, search_req;
  logic                   advance, prim_ok, force_prim, ref_grant, prim_grant;
  logic                   ref_accept, ref_keep, ref_drop;
  logic [DATA_W-1:0]      fifo_rd_data;
  logic [BOUNCE_W-1:0]    fifo_rd_bounce;
  logic                   fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;

  assign advance    = !out_valid_reg || out_ready;
  assign prim_ok    = (|prim_valid) && (in_flight_reg < IF_W'(MAX_INFLIGHT));
  assign ref_grant  = advance && !fifo_empty && !force_prim;
  assign prim_grant = advance && prim_ok && (fifo_empty || force_prim);

  assign ref_ready  = resetn && !fifo_full;
  assign ref_accept = ref_valid && ref_ready;
  assign ref_keep   = (ref_bounce < BOUNCE_W'(MAX_BOUNCE));
  assign ref_drop   = ref_accept && !ref_keep;

  // Round robin: prefer requesters at or above the pointer, else wrap to the lowest.
  for (genvar gi = 0; gi < NUM_PRIMARY; gi++) begin : g_chan
    assign upper_req[gi]  = prim_valid[gi] && (gi >= int'(rr_ptr_reg));
    assign prim_ready[gi] = resetn && prim_grant && (prim_sel == PTR_W'(gi));
  end

  always_comb begin
    search_req = (|upper_req) ? upper_req : prim_valid;
    prim_sel   = '0;
    for (int k = NUM_PRIMARY - 1; k >= 0; k--) begin
      if (search_req[k]) prim_sel = PTR_W'(k);
    end
  end

`ifdef RAY_SCHED_STARVE_GUARD_EN
  logic [2:0] starve_cnt_reg;

  assign force_prim = prim_ok && (starve_cnt_reg >= 3'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (!resetn)        starve_cnt_reg <= '0;
    else if (prim_grant) starve_cnt_reg <= '0;
    else if (ref_grant)  starve_cnt_reg <= prim_ok ? starve_cnt_reg + 3'd1 : 3'd0;
  end
`else
  assign force_prim = 1'b0;
`endif

  // Reflection grants are the same ray coming back, so only new primaries add to the count.
  always_comb begin
    in_flight_next = in_flight_reg + IF_W'(prim_grant);
    if (ray_done && in_flight_next != '0) in_flight_next = in_flight_next - IF_W'(1);
    if (ref_drop && in_flight_next != '0) in_flight_next = in_flight_next - IF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_bounce_reg <= '0;
      in_flight_reg  <= '0;
      drop_count_reg <= '0;
      rr_ptr_reg     <= '0;
    end else begin
      in_flight_reg <= in_flight_next;
      if (ref_drop && drop_count_reg != 16'hFFFF) drop_count_reg <= drop_count_reg + 16'd1;
      if (advance) begin
        out_valid_reg <= ref_grant || prim_grant;
        if (ref_grant) begin
          out_data_reg   <= fifo_rd_data;
          out_bounce_reg <= fifo_rd_bounce;
        end else if (prim_grant) begin
          out_data_reg   <= prim_data[prim_sel];
          out_bounce_reg <= '0;
        end
      end
      if (prim_grant) begin
        if (prim_sel == PTR_W'(NUM_PRIMARY - 1)) rr_ptr_reg <= '0;
        else                                      rr_ptr_reg <= prim_sel + PTR_W'(1);
      end
    end
  end

  ray_ref_fifo #(
    .DATA_W   (DATA_W),
    .BOUNCE_W (BOUNCE_W),
    .DEPTH    (REF_DEPTH)
  ) u_ref_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (ref_accept && ref_keep),
    .wr_data   (ref_data),
    .wr_bounce (ref_bounce + BOUNCE_W'(1)),
    .rd_en     (ref_grant),
    .rd_data   (fifo_rd_data),
    .rd_bounce (fifo_rd_bounce),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid     = out_valid_reg;
  assign out_data      = out_data_reg;
  assign out_bounce    = out_bounce_reg;
  assign in_flight     = in_flight_reg;
  assign drop_count    = drop_count_reg;
  assign ref_fifo_full = (fifo_count == CNT_W'(REF_DEPTH));

endmodule
